// File: rtl/mul_io_pkg.sv
// rtl/mul_io_pkg.sv - shared types and constants for the 8x8 multiplier host sequencer
package mul_io_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

  localparam logic HI_SEL_LO = 1'b0;
  localparam logic HI_SEL_HI = 1'b1;

  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_LO    = 3'd4,
    S_HI    = 3'd5
  } state_e;

endpackage

// File: rtl/mul_io_seq_strobe_sync.sv
// rtl/mul_io_seq_strobe_sync.sv - async host strobe synchroniser with rising-edge pulse
// The pulse is high for one cycle, SYNC_STAGES-1 edges after the pin rise is first sampled.
module strobe_sync
  import mul_io_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], stb_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/mul_io_seq.sv
// rtl/mul_io_seq.sv - host operand capture, core handshake and byte-serial result readout
// Optional accumulator of products enabled by defining MUL_IO_SEQ_ACCUM_EN.
module mul_io_seq
  import mul_io_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [WIDTH-1:0]   din,
  input  logic               wr_stb,
  input  logic               rd_stb,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_valid,
  input  logic               mul_ready,
  input  logic [2*WIDTH-1:0] prod,
  input  logic               prod_valid,
  output logic [WIDTH-1:0]   dout,
  output logic               hi_sel,
  output logic               busy,
  output logic               rdy
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 hi_sel_q, hi_sel_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic [2*WIDTH-1:0]   res_next;
  logic                 res_clr;
  logic                 wr_pulse, rd_pulse;
  logic                 wr_ev, rd_ev;

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .stb_i   (wr_stb),
    .pulse_o (wr_pulse)
  );

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .stb_i   (rd_stb),
    .pulse_o (rd_pulse)
  );

  // Deselected events are dropped, not deferred.
  assign wr_ev = wr_pulse & ena;
  assign rd_ev = rd_pulse & ena;

`ifdef MUL_IO_SEQ_ACCUM_EN
  assign res_next = res_q + prod;
  assign res_clr  = (din == '0);
`else
  assign res_next = prod;
  assign res_clr  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    dout_d   = dout_q;
    hi_sel_d = hi_sel_q;
    res_d    = res_q;
    unique case (state_q)
      S_A: begin
        if (wr_ev) begin
          mul_a_d = din;
          if (res_clr) res_d = '0;
          state_d = S_B;
        end
      end
      S_B: begin
        if (wr_ev) begin
          mul_b_d = din;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mul_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (prod_valid) begin
          res_d    = res_next;
          dout_d   = res_next[WIDTH-1:0];
          hi_sel_d = HI_SEL_LO;
          state_d  = S_LO;
        end
      end
      S_LO: begin
        // A new write abandons the unread result and wins over a read.
        if (wr_ev) begin
          mul_a_d = din;
          state_d = S_B;
        end else if (rd_ev) begin
          dout_d   = res_q[2*WIDTH-1:WIDTH];
          hi_sel_d = HI_SEL_HI;
          state_d  = S_HI;
        end
      end
      S_HI: begin
        if (wr_ev) begin
          mul_a_d = din;
          state_d = S_B;
        end else if (rd_ev) begin
          state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_A;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      dout_q   <= '0;
      hi_sel_q <= HI_SEL_LO;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      dout_q   <= dout_d;
      hi_sel_q <= hi_sel_d;
      res_q    <= res_d;
    end
  end

  // Decoded straight from state so they fall with reset, no clock needed.
  assign mul_valid = (state_q == S_ISSUE);
  assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign rdy       = (state_q == S_LO) || (state_q == S_HI);

  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;
  assign dout   = dout_q;
  assign hi_sel = hi_sel_q;

endmodule

// File: tb/tb_mul_io_seq.sv
// tb/tb_mul_io_seq.sv - randomized and directed bench for mul_io_seq against a behavioural model
module tb_mul_io_seq;

  localparam int W = 8;
  localparam int S = 2;

  localparam int P_A = 0, P_B = 1, P_ISSUE = 2, P_WAIT = 3, P_LO = 4, P_HI = 5;

  logic           clk = 1'b0;
  logic           rst_n, ena, wr_stb, rd_stb, mul_ready, prod_valid;
  logic [W-1:0]   din, mul_a, mul_b, dout;
  logic [2*W-1:0] prod;
  logic           mul_valid, hi_sel, busy, rdy;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  mul_io_seq #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .din        (din),
    .wr_stb     (wr_stb),
    .rd_stb     (rd_stb),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_valid  (mul_valid),
    .mul_ready  (mul_ready),
    .prod       (prod),
    .prod_valid (prod_valid),
    .dout       (dout),
    .hi_sel     (hi_sel),
    .busy       (busy),
    .rdy        (rdy)
  );

  // Behavioural model: pin history per edge, phase of the operation, held values.
  int             ph;
  logic [W-1:0]   m_a, m_b, m_dout;
  logic           m_hi;
  logic [2*W-1:0] m_res;
  logic [7:0]     wr_hist, rd_hist;
  bit             m_xfer;

  task automatic model_reset();
    ph = P_A; m_a = '0; m_b = '0; m_dout = '0; m_hi = 1'b0; m_res = '0;
    wr_hist = '0; rd_hist = '0; m_xfer = 1'b0;
  endtask

  task automatic model_edge();
    bit wr_ev, rd_ev;
    m_xfer = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wr_hist = {wr_hist[6:0], wr_stb};
    rd_hist = {rd_hist[6:0], rd_stb};
    // A pin rise first seen at edge E-S acts at edge E.
    wr_ev = ena && wr_hist[S] && !wr_hist[S+1];
    rd_ev = ena && rd_hist[S] && !rd_hist[S+1];
    case (ph)
      P_A: if (wr_ev) begin
`ifdef MUL_IO_SEQ_ACCUM_EN
        if (din == 8'h00) m_res = '0;
`endif
        m_a = din; ph = P_B;
      end
      P_B: if (wr_ev) begin m_b = din; ph = P_ISSUE; end
      P_ISSUE: if (mul_ready) begin m_xfer = 1'b1; ph = P_WAIT; end
      P_WAIT: if (prod_valid) begin
`ifdef MUL_IO_SEQ_ACCUM_EN
        m_res = m_res + prod;
`else
        m_res = prod;
`endif
        m_dout = m_res[W-1:0]; m_hi = 1'b0; ph = P_LO;
      end
      P_LO: if (wr_ev) begin m_a = din; ph = P_B; end
            else if (rd_ev) begin m_dout = m_res[2*W-1:W]; m_hi = 1'b1; ph = P_HI; end
      P_HI: if (wr_ev) begin m_a = din; ph = P_B; end
            else if (rd_ev) ph = P_A;
      default: ph = P_A;
    endcase
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      n_tests++;
      if (mul_a !== m_a || mul_b !== m_b || mul_valid !== (ph == P_ISSUE) ||
          busy !== (ph == P_ISSUE || ph == P_WAIT) || rdy !== (ph == P_LO || ph == P_HI) ||
          dout !== m_dout || hi_sel !== m_hi) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t: got a=%h b=%h v=%b busy=%b rdy=%b dout=%h hi=%b, expected a=%h b=%h v=%b busy=%b rdy=%b dout=%h hi=%b",
                 $time, mul_a, mul_b, mul_valid, busy, rdy, dout, hi_sel,
                 m_a, m_b, (ph == P_ISSUE), (ph == P_ISSUE || ph == P_WAIT), (ph == P_LO || ph == P_HI), m_dout, m_hi);
      end
    end
  end

  task automatic check8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic wr_pulse(input logic [W-1:0] d);
    din = d; wr_stb = 1'b1;
    repeat (S + 2) tick();
    wr_stb = 1'b0;
    repeat (2) tick();
  endtask

  task automatic rd_pulse();
    rd_stb = 1'b1;
    repeat (S + 2) tick();
    rd_stb = 1'b0;
    repeat (2) tick();
  endtask

  task automatic xfer();
    mul_ready = 1'b1; tick(); mul_ready = 1'b0; tick();
  endtask

  task automatic give_prod(input logic [2*W-1:0] p);
    prod = p; prod_valid = 1'b1; tick(); prod_valid = 1'b0; tick();
  endtask

  task automatic read_pair(input string name, input logic [W-1:0] lo, input logic [W-1:0] hi);
    check8({name, "_lo"}, dout, lo);
    rd_pulse();
    check8({name, "_hi"}, dout, hi);
    rd_pulse();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int wr_left, rd_left, core_cnt;
    logic [2*W-1:0] core_prod;
    rst_n = 1'b0; ena = 1'b0; wr_stb = 1'b0; rd_stb = 1'b0; din = '0;
    mul_ready = 1'b0; prod_valid = 1'b0; prod = '0;
    model_reset();
    cmp_en = 1'b1;
    repeat (3) tick();
    check8("rst_mul_a", mul_a, 8'h00);
    check8("rst_dout", dout, 8'h00);
    check1("rst_mul_valid", mul_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_rdy", rdy, 1'b0);
    check1("rst_hi_sel", hi_sel, 1'b0);
    rst_n = 1'b1; tick();

    // Strobes while deselected are discarded.
    wr_pulse(8'h55); wr_pulse(8'h66);
    check8("ena0_mul_a", mul_a, 8'h00);
    check1("ena0_busy", busy, 1'b0);
    ena = 1'b1;

    // 0x0C * 0x0B = 0x0084
    wr_pulse(8'h0C);
    check8("t1_mul_a", mul_a, 8'h0C);
    wr_pulse(8'h0B);
    check8("t1_mul_b", mul_b, 8'h0B);
    check1("t1_valid", mul_valid, 1'b1);
    mul_ready = 1'b1; tick(); mul_ready = 1'b0;
    check1("t1_valid_drop", mul_valid, 1'b0);
    check1("t1_busy_wait", busy, 1'b1);
    tick();
    give_prod(16'h0084);
    check1("t1_rdy", rdy, 1'b1);
    check1("t1_hi_sel_lo", hi_sel, 1'b0);
    check8("t1_lo", dout, 8'h84);
    rd_pulse();
    check1("t1_hi_sel_hi", hi_sel, 1'b1);
    check8("t1_hi", dout, 8'h00);
    rd_pulse();
    check1("t1_back_idle", rdy, 1'b0);
    check1("t1_not_busy", busy, 1'b0);

    // 0xFF * 0xFF with mul_ready held low for five cycles
    wr_pulse(8'hFF); wr_pulse(8'hFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("t2_valid_hold", mul_valid, 1'b1);
    end
    mul_ready = 1'b1; tick(); mul_ready = 1'b0;
    check1("t2_valid_drop", mul_valid, 1'b0);
    tick();
    give_prod(16'hFE01);
`ifdef MUL_IO_SEQ_ACCUM_EN
    read_pair("t2", 8'h85, 8'hFE);
`else
    read_pair("t2", 8'h01, 8'hFE);
`endif

    // Asynchronous reset while waiting for the product
    wr_pulse(8'h03); wr_pulse(8'h04); xfer();
    check1("t3_in_wait", busy, 1'b1);
    #2 rst_n = 1'b0; model_reset();
    #1;
    check1("t3_rst_valid", mul_valid, 1'b0);
    check1("t3_rst_busy", busy, 1'b0);
    check8("t3_rst_dout", dout, 8'h00);
    tick(); rst_n = 1'b1;
    give_prod(16'h1234);
    check1("t3_prod_ignored", rdy, 1'b0);
    check8("t3_dout_zero", dout, 8'h00);

    // Asynchronous reset while issuing drops mul_valid without a clock
    wr_pulse(8'h07); wr_pulse(8'h09);
    check1("t4_issue", mul_valid, 1'b1);
    #2 rst_n = 1'b0; model_reset();
    #1;
    check1("t4_rst_valid", mul_valid, 1'b0);
    check8("t4_rst_mul_a", mul_a, 8'h00);
    tick(); rst_n = 1'b1; tick();

    // Write action lands exactly SYNC_STAGES edges after the rise is sampled
    din = 8'h3C; wr_stb = 1'b1;
    tick(); check8("t5_edge_n", mul_a, 8'h00);
    tick(); check8("t5_edge_n1", mul_a, 8'h00);
    tick(); check8("t5_edge_n2", mul_a, 8'h3C);
    tick(); wr_stb = 1'b0; tick(); tick();
    wr_pulse(8'h02); xfer(); give_prod(16'h1278);
    check8("t5_lo", dout, 8'h78);
    rd_pulse();
    check8("t5_hi", dout, 8'h12);
    // Coincident write and read in S_HI: write wins
    din = 8'h5A; wr_stb = 1'b1; rd_stb = 1'b1;
    repeat (S + 2) tick();
    wr_stb = 1'b0; rd_stb = 1'b0; tick(); tick();
    check8("t5_coinc_mul_a", mul_a, 8'h5A);
    check1("t5_coinc_rdy", rdy, 1'b0);
    check1("t5_coinc_busy", busy, 1'b0);
    // prod_valid outside the wait state is ignored
    give_prod(16'hBEEF);
    check8("t5_spurious_dout", dout, 8'h12);
    check1("t5_spurious_rdy", rdy, 1'b0);

`ifdef MUL_IO_SEQ_ACCUM_EN
    wr_pulse(8'h01); xfer(); give_prod(16'h0000); rd_pulse(); rd_pulse();
    wr_pulse(8'h00); wr_pulse(8'hFF); xfer(); give_prod(16'h0000); rd_pulse(); rd_pulse();
    wr_pulse(8'hFF); wr_pulse(8'hFF); xfer(); give_prod(16'hFE01);
    read_pair("acc1", 8'h01, 8'hFE);
    wr_pulse(8'hFF); wr_pulse(8'hFF); xfer(); give_prod(16'hFE01);
    read_pair("acc2", 8'h02, 8'hFC);
`endif

    // Randomized traffic with a reactive core stand-in
    wr_left = 0; rd_left = 0; core_cnt = 0; core_prod = '0;
    for (int c = 0; c < 3000; c++) begin
      ena = ($urandom_range(0, 9) != 0);
      mul_ready = ($urandom_range(0, 2) == 0);
      if (core_cnt == 1) begin
        prod_valid = 1'b1; prod = core_prod;
      end else begin
        prod_valid = ($urandom_range(0, 29) == 0);
        prod = 16'($urandom);
      end
      if (wr_stb) begin
        if (wr_left == 0) begin wr_stb = 1'b0; wr_left = $urandom_range(1, 6); end
        else wr_left--;
      end else if (wr_left == 0) begin
        if ($urandom_range(0, 5) == 0) begin
          din = 8'($urandom); wr_stb = 1'b1; wr_left = $urandom_range(2, 6);
        end
      end else wr_left--;
      if (rd_stb) begin
        if (rd_left == 0) begin rd_stb = 1'b0; rd_left = $urandom_range(1, 4); end
        else rd_left--;
      end else if (rd_left == 0) begin
        if ($urandom_range(0, 3) == 0) begin rd_stb = 1'b1; rd_left = $urandom_range(2, 5); end
      end else rd_left--;
      tick();
      if (core_cnt > 0) core_cnt--;
      if (m_xfer) begin
        core_cnt  = $urandom_range(1, 4);
        core_prod = 16'(m_a) * 16'(m_b);
      end
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
